// File: rtl/btn_pkg.sv
// Shared types for the pushbutton input conditioner.
// Debounce state encoding and counter-width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    DISARMING = 2'd3
  } dbs_t;

  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button: 2-flop synchroniser, debounce FSM, one-cycle press event.
// Auto-repeat while held when DUAL_BUTTON_CONDITIONER_REPEAT_EN is defined.
module button_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press_evt
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic s1, s2;
  dbs_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;

`ifdef DUAL_BUTTON_CONDITIONER_REPEAT_EN
  localparam int RW = cnt_w(REPEAT_CYCLES);
  localparam logic [RW-1:0] RLAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rcnt, rcnt_n;

  always_ff @(posedge clk) begin
    if (reset) rcnt <= '0;
    else       rcnt <= rcnt_n;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    press_evt = 1'b0;
`ifdef DUAL_BUTTON_CONDITIONER_REPEAT_EN
    rcnt_n    = '0;
`endif
    unique case (state)
      IDLE: begin
        if (s2) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_n   = PRESSED;
            cnt_n     = '0;
            press_evt = 1'b1;
          end else begin
            state_n = ARMING;
            cnt_n   = ONE;
          end
        end
      end
      ARMING: begin
        if (!s2) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n   = PRESSED;
          cnt_n     = '0;
          press_evt = 1'b1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      PRESSED: begin
        if (!s2) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            state_n = DISARMING;
            cnt_n   = ONE;
          end
        end
`ifdef DUAL_BUTTON_CONDITIONER_REPEAT_EN
        // period counts from the edge that entered PRESSED
        else if (rcnt == RLAST) begin
          press_evt = 1'b1;
          rcnt_n    = '0;
        end else begin
          rcnt_n = rcnt + RW'(1);
        end
`endif
      end
      DISARMING: begin
        if (s2) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: rtl/dual_button_conditioner.sv
// Two debounced buttons into mutually exclusive one-cycle P1/P2 pulses.
// Optional auto-repeat: define DUAL_BUTTON_CONDITIONER_REPEAT_EN.
module dual_button_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn1_raw,
  input  logic btn2_raw,
  output logic P1,
  output logic P2
);

  logic evt1, evt2, pend2;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_b1 (
    .clk      (clk),
    .reset    (reset),
    .raw      (btn1_raw),
    .press_evt(evt1)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_b2 (
    .clk      (clk),
    .reset    (reset),
    .raw      (btn2_raw),
    .press_evt(evt2)
  );

  // P1 wins a collision; button 2 is held one cycle in pend2.
  // A button's events are >= 2 cycles apart, so pend2 always drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      P1    <= 1'b0;
      P2    <= 1'b0;
      pend2 <= 1'b0;
    end else if (evt1) begin
      P1    <= 1'b1;
      P2    <= 1'b0;
      pend2 <= pend2 | evt2;
    end else begin
      P1    <= 1'b0;
      P2    <= pend2 | evt2;
      pend2 <= pend2 & evt2;
    end
  end

endmodule

// File: tb/tb_dual_button_conditioner.sv
// Directed bench: DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, edge-by-edge checks.
// Expected pulse edges are hand-derived for both repeat builds.
module tb_dual_button_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn1_raw = 1'b0;
  logic btn2_raw = 1'b0;
  logic P1, P2;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  dual_button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn1_raw(btn1_raw),
    .btn2_raw(btn2_raw),
    .P1      (P1),
    .P2      (P2)
  );

  always #5 clk = ~clk;

  function automatic logic exp_p1(input int e);
`ifdef DUAL_BUTTON_CONDITIONER_REPEAT_EN
    return (e == 15) || (e == 23) || (e == 45) ||
           (e == 69) || (e == 77) || (e == 85) || (e == 93);
`else
    return (e == 15) || (e == 45) || (e == 69);
`endif
  endfunction

  function automatic logic exp_p2(input int e);
    return (e == 25) || (e == 46);
  endfunction

  task automatic chk(input string tag, input int e,
                     input logic got, input logic exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s edge %0d got %b exp %b", tag, e, got, exp);
    end
  endtask

  initial begin
    for (int e = 1; e <= 105; e++) begin
      // inputs for the upcoming edge e
      reset    = (e <= 2) || (e == 63);
      btn1_raw = (e >= 10 && e < 30 && e != 22) ||
                 (e >= 40 && e < 47) ||
                 (e >= 60 && e < 95);
      btn2_raw = (e >= 16 && e <= 18) ||
                 (e >= 20 && e < 30) ||
                 (e >= 40 && e < 47);
      @(posedge clk);
      #1;
      chk("p1", e, P1, exp_p1(e));
      chk("p2", e, P2, exp_p2(e));
      chk("excl", e, P1 & P2, 1'b0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
